alu_rs: RTL and testbench

- Reservation station feeding the parallel ALU lanes.
- Accepts one dispatched ALU op per cycle and holds up to `size` entries.
- Snoops the common data bus (CDB) for missing operands.
- Presents each entry whose operands are both resolved to its fixed ALU lane through the `rs_t data[size]` / `ready[size]` interface.
- Frees an entry the cycle after it issues.

---
 rtl/alu_rs_pkg.sv | 42 ++++
 rtl/alu_rs_cdb_match.sv | 26 ++
 rtl/alu_rs.sv | 114 +++++++++++
 tb/tb_alu_rs.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared types for the ALU reservation station
package alu_rs_pkg;

  typedef logic [3:0] rs_tag_t;

  typedef enum logic [2:0] {
    alu_add = 3'd0,
    alu_sll = 3'd1,
    alu_sra = 3'd2,
    alu_sub = 3'd3,
    alu_xor = 3'd4,
    alu_srl = 3'd5,
    alu_or  = 3'd6,
    alu_and = 3'd7
  } alu_ops;

  typedef struct packed {
    alu_ops      operation;
    logic [31:0] r1;
    logic [31:0] r2;
    rs_tag_t     tag;
  } rs_t;

  typedef struct packed {
    logic        rdy;
    rs_tag_t     tag;
    logic [31:0] data;
  } sal_t;

  typedef struct packed {
    logic        valid;
    alu_ops      op;
    rs_tag_t     tag;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        r1_ok;
    logic        r2_ok;
    rs_tag_t     q1;
    rs_tag_t     q2;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_cdb_match.sv
// rtl/alu_rs_cdb_match.sv - finds the CDB lane resolving one pending operand
module alu_rs_cdb_match
  import alu_rs_pkg::*;
#(
  parameter int cdb_size = 8
) (
  input  rs_tag_t     q,
  input  logic        ok,
  input  sal_t        cdb [cdb_size],
  output logic        hit,
  output logic [31:0] data
);

  // Scan from the top so the lowest matching lane is the one left standing.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int l = cdb_size - 1; l >= 0; l--) begin
      if (!ok && cdb[l].rdy && (cdb[l].tag == q)) begin
        hit  = 1'b1;
        data = cdb[l].data;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding one fixed ALU lane per entry
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int size     = 8,
  parameter int cdb_size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dis_valid,
  input  alu_ops          dis_op,
  input  rs_tag_t         dis_tag,
  input  logic [31:0]     dis_r1,
  input  logic [31:0]     dis_r2,
  input  logic            dis_r1_rdy,
  input  logic            dis_r2_rdy,
  input  rs_tag_t         dis_q1,
  input  rs_tag_t         dis_q2,
  input  sal_t            cdb [cdb_size],
  output logic            rs_full,
  output rs_t             data [size],
  output logic [size-1:0] ready
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;

  rs_entry_t         entries_q [size];
  rs_entry_t         entries_d [size];
  logic [size-1:0]   valid_vec;
  logic [size-1:0]   hit1;
  logic [size-1:0]   hit2;
  logic [31:0]       wake1 [size];
  logic [31:0]       wake2 [size];
  logic              byp1_hit;
  logic              byp2_hit;
  logic [31:0]       byp1_data;
  logic [31:0]       byp2_data;
  logic [IDX_W-1:0]  alloc_idx;
  logic              accept;

  for (genvar i = 0; i < size; i++) begin : g_entry
    alu_rs_cdb_match #(.cdb_size(cdb_size)) u_match1 (
      .q(entries_q[i].q1), .ok(entries_q[i].r1_ok), .cdb(cdb),
      .hit(hit1[i]), .data(wake1[i])
    );
    alu_rs_cdb_match #(.cdb_size(cdb_size)) u_match2 (
      .q(entries_q[i].q2), .ok(entries_q[i].r2_ok), .cdb(cdb),
      .hit(hit2[i]), .data(wake2[i])
    );

    assign valid_vec[i] = entries_q[i].valid;
    assign ready[i]     = entries_q[i].valid && entries_q[i].r1_ok && entries_q[i].r2_ok;
    assign data[i]      = entries_q[i].valid
                          ? {entries_q[i].op, entries_q[i].v1, entries_q[i].v2, entries_q[i].tag}
                          : '0;
  end

  // A dispatched operand may be broadcast in the very cycle it arrives.
  alu_rs_cdb_match #(.cdb_size(cdb_size)) u_byp1 (
    .q(dis_q1), .ok(dis_r1_rdy), .cdb(cdb), .hit(byp1_hit), .data(byp1_data)
  );
  alu_rs_cdb_match #(.cdb_size(cdb_size)) u_byp2 (
    .q(dis_q2), .ok(dis_r2_rdy), .cdb(cdb), .hit(byp2_hit), .data(byp2_data)
  );

  always_comb begin
    rs_full   = &valid_vec;
    accept    = dis_valid && !rs_full;
    alloc_idx = '0;
    for (int i = size - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end

    for (int i = 0; i < size; i++) begin
      entries_d[i] = entries_q[i];
      if (ready[i]) begin
        entries_d[i].valid = 1'b0;
      end else if (entries_q[i].valid) begin
        if (hit1[i]) begin
          entries_d[i].r1_ok = 1'b1;
          entries_d[i].v1    = wake1[i];
        end
        if (hit2[i]) begin
          entries_d[i].r2_ok = 1'b1;
          entries_d[i].v2    = wake2[i];
        end
      end

      if (accept && (alloc_idx == IDX_W'(i))) begin
        entries_d[i].valid = 1'b1;
        entries_d[i].op    = dis_op;
        entries_d[i].tag   = dis_tag;
        entries_d[i].q1    = dis_q1;
        entries_d[i].q2    = dis_q2;
        entries_d[i].r1_ok = dis_r1_rdy || byp1_hit;
        entries_d[i].r2_ok = dis_r2_rdy || byp2_hit;
        entries_d[i].v1    = byp1_hit ? byp1_data : dis_r1;
        entries_d[i].v2    = byp2_hit ? byp2_data : dis_r2;
      end

      if (flush) entries_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < size; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < size; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - randomized and directed bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 8;
  localparam int C = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dis_valid;
  alu_ops      dis_op;
  rs_tag_t     dis_tag;
  logic [31:0] dis_r1;
  logic [31:0] dis_r2;
  logic        dis_r1_rdy;
  logic        dis_r2_rdy;
  rs_tag_t     dis_q1;
  rs_tag_t     dis_q2;
  sal_t        cdb [C];
  logic        rs_full;
  rs_t         data [N];
  logic [N-1:0] ready;

  int vectors = 0;
  int miscompares = 0;

  bit          m_v   [N];
  bit          m_ok1 [N];
  bit          m_ok2 [N];
  logic [2:0]  m_op  [N];
  logic [3:0]  m_tag [N];
  logic [3:0]  m_q1  [N];
  logic [3:0]  m_q2  [N];
  logic [31:0] m_a   [N];
  logic [31:0] m_b   [N];

  always #5 clk = ~clk;

  alu_rs #(.size(N), .cdb_size(C)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dis_valid(dis_valid), .dis_op(dis_op),
    .dis_tag(dis_tag), .dis_r1(dis_r1), .dis_r2(dis_r2), .dis_r1_rdy(dis_r1_rdy),
    .dis_r2_rdy(dis_r2_rdy), .dis_q1(dis_q1), .dis_q2(dis_q2), .cdb(cdb),
    .rs_full(rs_full), .data(data), .ready(ready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_ok1[i] = 0; m_ok2[i] = 0;
      m_op[i] = '0; m_tag[i] = '0; m_q1[i] = '0; m_q2[i] = '0; m_a[i] = '0; m_b[i] = '0;
    end
  endtask

  task automatic lookup(input logic [3:0] q, output bit h, output logic [31:0] d);
    h = 0;
    d = '0;
    for (int l = 0; l < C; l++) begin
      if (!h && cdb[l].rdy && cdb[l].tag == q) begin
        h = 1;
        d = cdb[l].data;
      end
    end
  endtask

  // Advance the reference by one clock using the inputs currently driven.
  task automatic m_step();
    int          slot = -1;
    bit          full = 1;
    bit          h;
    logic [31:0] d;
    for (int i = 0; i < N; i++) begin
      if (!m_v[i]) begin
        full = 0;
        if (slot < 0) slot = i;
      end
    end
    if (flush) begin
      m_clear();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        if (m_ok1[i] && m_ok2[i]) m_v[i] = 0;
        else begin
          if (!m_ok1[i]) begin
            lookup(m_q1[i], h, d);
            if (h) begin m_ok1[i] = 1; m_a[i] = d; end
          end
          if (!m_ok2[i]) begin
            lookup(m_q2[i], h, d);
            if (h) begin m_ok2[i] = 1; m_b[i] = d; end
          end
        end
      end
    end
    if (dis_valid && !full) begin
      m_v[slot] = 1; m_op[slot] = dis_op; m_tag[slot] = dis_tag;
      m_q1[slot] = dis_q1; m_q2[slot] = dis_q2;
      m_ok1[slot] = dis_r1_rdy; m_a[slot] = dis_r1;
      m_ok2[slot] = dis_r2_rdy; m_b[slot] = dis_r2;
      if (!dis_r1_rdy) begin
        lookup(dis_q1, h, d);
        if (h) begin m_ok1[slot] = 1; m_a[slot] = d; end
      end
      if (!dis_r2_rdy) begin
        lookup(dis_q2, h, d);
        if (h) begin m_ok2[slot] = 1; m_b[slot] = d; end
      end
    end
  endtask

  task automatic compare_outputs();
    bit full = 1;
    for (int i = 0; i < N; i++) if (!m_v[i]) full = 0;
    check("rs_full", rs_full, full);
    for (int i = 0; i < N; i++) begin
      check($sformatf("ready[%0d]", i), ready[i], m_v[i] && m_ok1[i] && m_ok2[i]);
      check($sformatf("data[%0d]", i), data[i],
            m_v[i] ? {m_op[i], m_a[i], m_b[i], m_tag[i]} : 71'd0);
    end
  endtask

  task automatic set_idle();
    flush = 0; dis_valid = 0; dis_op = alu_add; dis_tag = '0;
    dis_r1 = '0; dis_r2 = '0; dis_r1_rdy = 0; dis_r2_rdy = 0; dis_q1 = '0; dis_q2 = '0;
    for (int l = 0; l < C; l++) cdb[l] = '0;
  endtask

  task automatic set_dis(input alu_ops op, input logic [3:0] tag,
                         input logic [31:0] r1, input logic r1_rdy, input logic [3:0] q1,
                         input logic [31:0] r2, input logic r2_rdy, input logic [3:0] q2);
    dis_valid = 1; dis_op = op; dis_tag = tag;
    dis_r1 = r1; dis_r1_rdy = r1_rdy; dis_q1 = q1;
    dis_r2 = r2; dis_r2_rdy = r2_rdy; dis_q2 = q2;
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst = 0;
    set_idle();
    m_clear();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    set_idle();
    m_clear();
    @(negedge clk);

    // Both operands ready: issue next cycle, free the one after.
    do_reset();
    check("t1_reset_full", rs_full, 1'b0);
    set_dis(alu_add, 4'd3, 32'd5, 1, 4'd0, 32'd7, 1, 4'd0);
    step();
    set_idle();
    check("t1_ready0", ready[0], 1'b1);
    check("t1_data0", data[0], {3'(alu_add), 32'd5, 32'd7, 4'd3});
    step();
    check("t1_ready_clear", ready, 8'h00);

    // CDB wakeup of a waiting operand.
    do_reset();
    set_dis(alu_sub, 4'd4, 32'd0, 0, 4'd2, 32'd10, 1, 4'd0);
    step();
    set_idle();
    step();
    check("t2_wait", ready[0], 1'b0);
    cdb[1] = '{rdy: 1'b1, tag: 4'd2, data: 32'd20};
    step();
    set_idle();
    check("t2_ready0", ready[0], 1'b1);
    check("t2_data0", data[0], {3'(alu_sub), 32'd20, 32'd10, 4'd4});
    step();

    // Broadcast in the dispatch cycle is captured.
    do_reset();
    set_dis(alu_add, 4'd5, 32'd0, 0, 4'd6, 32'd1, 1, 4'd0);
    cdb[0] = '{rdy: 1'b1, tag: 4'd6, data: 32'h55};
    step();
    set_idle();
    check("t3_ready0", ready[0], 1'b1);
    check("t3_r1", data[0].r1, 32'h55);
    step();

    // Fill, block a ninth dispatch, release all at once.
    do_reset();
    for (int k = 0; k < N; k++) begin
      set_dis(alu_or, 4'(k), 32'd0, 0, 4'd9, 32'(k), 1, 4'd0);
      step();
    end
    check("t4_full", rs_full, 1'b1);
    set_dis(alu_and, 4'd15, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0);
    step();
    set_idle();
    check("t4_still_full", rs_full, 1'b1);
    check("t4_none_ready", ready, 8'h00);
    cdb[3] = '{rdy: 1'b1, tag: 4'd9, data: 32'hABCD};
    step();
    set_idle();
    check("t4_all_ready", ready, 8'hFF);
    step();
    check("t4_not_full", rs_full, 1'b0);

    // Flush beats dispatch and wakeup.
    do_reset();
    set_dis(alu_xor, 4'd1, 32'd0, 0, 4'd12, 32'd3, 1, 4'd0);
    step();
    set_dis(alu_xor, 4'd2, 32'd4, 1, 4'd0, 32'd5, 1, 4'd0);
    step();
    set_dis(alu_xor, 4'd7, 32'd6, 1, 4'd0, 32'd0, 0, 4'd12);
    step();
    set_idle();
    step();
    set_dis(alu_sll, 4'd8, 32'd1, 1, 4'd0, 32'd1, 1, 4'd0);
    flush = 1;
    cdb[0] = '{rdy: 1'b1, tag: 4'd12, data: 32'h77};
    step();
    set_idle();
    check("t5_ready", ready, 8'h00);
    check("t5_data0", data[0], 71'd0);
    step();
    check("t5_ready_after", ready, 8'h00);

    // Asynchronous reset mid-cycle.
    do_reset();
    set_dis(alu_srl, 4'd10, 32'd0, 0, 4'd13, 32'd1, 1, 4'd0);
    step();
    set_dis(alu_srl, 4'd11, 32'd2, 1, 4'd0, 32'd3, 1, 4'd0);
    step();
    set_idle();
    check("t6_pre_ready1", ready[1], 1'b1);
    #2;
    rst = 0;
    #1;
    check("t6_async_ready", ready, 8'h00);
    check("t6_async_full", rs_full, 1'b0);
    check("t6_async_data1", data[1], 71'd0);
    m_clear();
    @(negedge clk);
    compare_outputs();
    rst = 1;

    // Randomized traffic against the reference.
    for (int c = 0; c < 1500; c++) begin
      dis_valid  = ($urandom_range(0, 9) < 7);
      dis_op     = alu_ops'($urandom_range(0, 7));
      dis_tag    = rs_tag_t'($urandom);
      dis_r1     = $urandom;
      dis_r2     = $urandom;
      dis_r1_rdy = 1'($urandom_range(0, 1));
      dis_r2_rdy = 1'($urandom_range(0, 1));
      dis_q1     = rs_tag_t'($urandom);
      dis_q2     = rs_tag_t'($urandom);
      flush      = ($urandom_range(0, 49) == 0);
      for (int l = 0; l < C; l++) begin
        cdb[l].rdy  = ($urandom_range(0, 9) < 2);
        cdb[l].tag  = rs_tag_t'($urandom);
        cdb[l].data = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
